// File: rtl/seq_trojan_trigger.sv
// Sequence-based Trojan trigger: fires once an ordered run of DEPTH state patterns
// has been observed THRESHOLD times, with an optional inter-step timeout.
module seq_trojan_trigger #(
    parameter int                         WIDTH     = 128,
    parameter int                         DEPTH     = 2,
    parameter logic [DEPTH*WIDTH-1:0]     PATTERNS  = {128'h00112233_44556677_8899aabb_ccddeeff,
                                                       128'hffeeddcc_bbaa9988_77665544_33221100},
    parameter int                         THRESHOLD = 1,
    parameter int                         TIMEOUT   = 0,
    parameter int                         CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         state_valid,
    input  logic [WIDTH-1:0]             state,
    output logic                         Tj_Trig,
    output logic [$clog2(DEPTH+1)-1:0]   seq_step,
    output logic [CNT_W-1:0]             hit_count
);

    localparam int SEQ_W = $clog2(DEPTH+1);
    localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_FIRED  = 2'd2;

    logic [1:0]       r_state;
    logic [SEQ_W-1:0] r_seq_step;
    logic [CNT_W-1:0] r_hit_count;
    logic [GAP_W-1:0] r_gap;
    logic             r_trig;

    logic [1:0]       w_state_next;
    logic [SEQ_W-1:0] w_step_next;
    logic [CNT_W-1:0] w_hit_next;
    logic [GAP_W-1:0] w_gap_next;
    logic             w_trig_next;

    logic [DEPTH-1:0] w_hit;
    logic             w_cur_match;
    logic             w_last_step;
    logic             w_expire;
    logic [CNT_W-1:0] w_hit_inc;

    // Step 0 occupies the most-significant slice of PATTERNS.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pat
            assign w_hit[gi] = (state == PATTERNS[WIDTH*(DEPTH-gi)-1 -: WIDTH]);
        end
    endgenerate

    always_comb begin
        w_cur_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_seq_step == SEQ_W'(k)) begin
                w_cur_match = w_hit[k];
            end
        end
    end

    assign w_last_step = (r_seq_step == SEQ_W'(DEPTH-1));
    assign w_hit_inc   = r_hit_count + CNT_W'(1);
    assign w_expire    = (TIMEOUT > 0) && (r_state == ST_TRACK) &&
                         (r_gap == GAP_W'(TIMEOUT-1));

    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_seq_step;
        w_hit_next   = r_hit_count;
        w_gap_next   = r_gap;
        w_trig_next  = r_trig;

        if (r_state != ST_FIRED) begin
            if ((TIMEOUT > 0) && (r_state == ST_TRACK)) begin
                w_gap_next = r_gap + GAP_W'(1);
            end

            // A matching sample wins over timeout expiry in the same cycle.
            if (state_valid && w_cur_match) begin
                w_gap_next = '0;
                if (w_last_step) begin
                    w_step_next  = '0;
                    w_hit_next   = w_hit_inc;
                    w_state_next = ST_SEARCH;
                    if (w_hit_inc == CNT_W'(THRESHOLD)) begin
                        w_state_next = ST_FIRED;
                        w_trig_next  = 1'b1;
                    end
                end else begin
                    w_step_next  = r_seq_step + SEQ_W'(1);
                    w_state_next = ST_TRACK;
                end
            end else if (w_expire) begin
                w_step_next  = '0;
                w_gap_next   = '0;
                w_state_next = ST_SEARCH;
            end else if (state_valid && (r_state == ST_TRACK)) begin
                w_gap_next = '0;
                if (w_hit[0]) begin
                    w_step_next  = SEQ_W'(1);
                    w_state_next = ST_TRACK;
                end else begin
                    w_step_next  = '0;
                    w_state_next = ST_SEARCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_seq_step  <= '0;
            r_hit_count <= '0;
            r_gap       <= '0;
            r_trig      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_seq_step  <= w_step_next;
            r_hit_count <= w_hit_next;
            r_gap       <= w_gap_next;
            r_trig      <= w_trig_next;
        end
    end

    assign Tj_Trig   = r_trig;
    assign seq_step  = r_seq_step;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_seq_trojan_trigger.sv
// Directed bench: four trigger configurations share one stimulus stream; each
// phase resets them all and checks the instance it targets.
module tb_seq_trojan_trigger;

    localparam logic [127:0] P0 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] P1 = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] PX = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
    localparam logic [127:0] PY = 128'h0badf00d_cafebabe_13579bdf_2468ace0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         state_valid = 1'b0;
    logic [127:0] state = '0;

    logic       def_trig, th3_trig, to4_trig, d1_trig;
    logic [1:0] def_step, th3_step, to4_step;
    logic       d1_step;
    logic [7:0] def_hit, th3_hit, to4_hit, d1_hit;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_trojan_trigger u_def (
        .clk(clk), .rst(rst), .state_valid(state_valid), .state(state),
        .Tj_Trig(def_trig), .seq_step(def_step), .hit_count(def_hit)
    );

    seq_trojan_trigger #(.THRESHOLD(3)) u_th3 (
        .clk(clk), .rst(rst), .state_valid(state_valid), .state(state),
        .Tj_Trig(th3_trig), .seq_step(th3_step), .hit_count(th3_hit)
    );

    seq_trojan_trigger #(.TIMEOUT(4)) u_to4 (
        .clk(clk), .rst(rst), .state_valid(state_valid), .state(state),
        .Tj_Trig(to4_trig), .seq_step(to4_step), .hit_count(to4_hit)
    );

    seq_trojan_trigger #(.DEPTH(1), .PATTERNS(P0), .THRESHOLD(2)) u_d1 (
        .clk(clk), .rst(rst), .state_valid(state_valid), .state(state),
        .Tj_Trig(d1_trig), .seq_step(d1_step), .hit_count(d1_hit)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Present one sample for one clock edge; outputs are sampled 1ns after the edge.
    task automatic drive(input logic v, input logic [127:0] s);
        state_valid = v;
        state       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        state_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reset edge with a live sample on the bus to prove reset has priority.
    task automatic pulse_reset();
        rst = 1'b1;
        drive(1'b1, P1);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst def_trig", def_trig, 0);
        check("rst def_step", def_step, 0);
        check("rst def_hit", def_hit, 0);
        check("rst th3_hit", th3_hit, 0);
        check("rst to4_step", to4_step, 0);
        check("rst d1_hit", d1_hit, 0);

        // 1: basic two-step sequence fires with latency 1 and stays sticky
        drive(1'b1, P0);
        check("t1 step after P0", def_step, 1);
        check("t1 trig after P0", def_trig, 0);
        drive(1'b1, P1);
        check("t1 step after P1", def_step, 0);
        check("t1 hit after P1", def_hit, 1);
        check("t1 trig after P1", def_trig, 1);
        check("t1 th3 hit", th3_hit, 1);
        check("t1 th3 trig", th3_trig, 0);
        drive(1'b1, P0);
        drive(1'b1, PX);
        drive(1'b0, P1);
        drive(1'b1, P1);
        check("t1 fired trig", def_trig, 1);
        check("t1 fired hit", def_hit, 1);
        check("t1 fired step", def_step, 0);

        // 2: broken sequence, then restart on repeated PAT[0]
        do_reset();
        drive(1'b1, P0);
        check("t2 step P0", def_step, 1);
        drive(1'b1, PX);
        check("t2 step X", def_step, 0);
        drive(1'b1, P1);
        check("t2 step P1", def_step, 0);
        check("t2 trig no", def_trig, 0);
        drive(1'b1, P0);
        drive(1'b1, P0);
        check("t2 restart step", def_step, 1);
        drive(1'b1, P1);
        check("t2 restart trig", def_trig, 1);
        check("t2 restart hit", def_hit, 1);

        // 3: THRESHOLD=3 with invalid gaps inside each sequence
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, P0);
            drive(1'b0, PY);
            check("t3 step hold over gap", th3_step, 1);
            drive(1'b1, P1);
            check("t3 hit", th3_hit, i);
            check("t3 trig", th3_trig, (i == 3) ? 1 : 0);
        end
        drive(1'b1, P0);
        drive(1'b1, P1);
        check("t3 hit saturated", th3_hit, 3);
        check("t3 step fired", th3_step, 0);

        // 4: TIMEOUT=4, match on the 4th cycle after PAT[0] still completes
        do_reset();
        drive(1'b1, P0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, P1);
            check("t4 step waiting", to4_step, 1);
        end
        drive(1'b1, P1);
        check("t4 hit in time", to4_hit, 1);
        check("t4 trig in time", to4_trig, 1);

        // 4b: match on the 5th cycle is too late
        do_reset();
        drive(1'b1, P0);
        repeat (3) drive(1'b0, P1);
        check("t4b step before expiry", to4_step, 1);
        drive(1'b0, P1);
        check("t4b step expired", to4_step, 0);
        drive(1'b1, P1);
        check("t4b late hit", to4_hit, 0);
        check("t4b late trig", to4_trig, 0);
        check("t4b no-timeout def trig", def_trig, 1);

        // 5: reset mid-sequence and while fired, then PAT[1] alone does nothing
        do_reset();
        drive(1'b1, P0);
        check("t5 step before rst", def_step, 1);
        pulse_reset();
        check("t5 step after rst", def_step, 0);
        check("t5 hit after rst", def_hit, 0);
        check("t5 trig after rst", def_trig, 0);
        drive(1'b1, P1);
        check("t5 P1 alone", def_step, 0);
        drive(1'b1, P0);
        drive(1'b1, P1);
        check("t5 fired", def_trig, 1);
        pulse_reset();
        check("t5 fired rst trig", def_trig, 0);
        check("t5 fired rst hit", def_hit, 0);
        check("t5 fired rst step", def_step, 0);
        drive(1'b1, P1);
        check("t5 post rst P1", def_step, 0);
        check("t5 post rst hit", def_hit, 0);

        // 6: DEPTH=1, THRESHOLD=2
        do_reset();
        drive(1'b1, P0);
        check("t6 hit 1", d1_hit, 1);
        check("t6 trig 1", d1_trig, 0);
        check("t6 step 1", d1_step, 0);
        drive(1'b0, P0);
        check("t6 invalid ignored", d1_hit, 1);
        drive(1'b1, P0);
        check("t6 hit 2", d1_hit, 2);
        check("t6 trig 2", d1_trig, 1);
        drive(1'b1, P0);
        check("t6 hit saturated", d1_hit, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
